// File: rtl/player_control.sv
// player_control: two-player movement FSM with crash detection and map write-select sequencing.
package game_pkg;
  localparam int MAP_WIDTH = 16;
  localparam int MAP_HEIGHT = 16;
  localparam int XW = $clog2(MAP_WIDTH);
  localparam int YW = $clog2(MAP_HEIGHT);
  typedef enum logic [1:0] {EMPTY, FRAME, TRAIL_1, TRAIL_2} tile;
  localparam logic [7:0] start_x_1 = 8'd4;
  localparam logic [7:0] start_y_1 = 8'd6;
  localparam logic [7:0] start_x_2 = 8'd12;
  localparam logic [7:0] start_y_2 = 8'd6;
endpackage

module player_control import game_pkg::*; #(
  parameter int MOVE_PERIOD = 650000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] dir_1,
  input  logic [1:0] dir_2,
  input  tile        map [MAP_WIDTH][MAP_HEIGHT],
  output logic [7:0] current_x_1,
  output logic [7:0] current_y_1,
  output logic [7:0] current_x_2,
  output logic [7:0] current_y_2,
  output logic [1:0] selected_player,
  output logic       game_over,
  output logic [1:0] winner
);
  localparam int CW = $clog2(MOVE_PERIOD);
  localparam logic [1:0] UP = 2'b00, RIGHT = 2'b01, DOWN = 2'b10, LEFT = 2'b11;
  typedef enum logic [2:0] {IDLE, RUN, STEP, CHECK, WRITE_P1, WRITE_P2, OVER} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] pend_q [2], pend_d [2], app_q [2], app_d [2], dir_in [2];
  logic [7:0] cur_x_q [2], cur_x_d [2], cur_y_q [2], cur_y_d [2];
  logic [7:0] nx_q [2], nx_d [2], ny_q [2], ny_d [2];
  logic       go_q, go_d;
  logic [1:0] win_q, win_d;
  logic [1:0] crash;
  logic       same;
  assign dir_in[0] = dir_1;
  assign dir_in[1] = dir_2;
  assign same = (nx_q[0] == nx_q[1]) && (ny_q[0] == ny_q[1]);
  // Out-of-range positions short-circuit before the map lookup, so the truncated index is never trusted.
  always_comb begin
    for (int p = 0; p < 2; p++)
      crash[p] = (nx_q[p] >= 8'(MAP_WIDTH)) || (ny_q[p] >= 8'(MAP_HEIGHT)) ||
                 (map[nx_q[p][XW-1:0]][ny_q[p][YW-1:0]] != EMPTY) || same;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_d    = go_q;
    win_d   = win_q;
    for (int p = 0; p < 2; p++) begin
      pend_d[p]  = (dir_in[p] == (app_q[p] ^ 2'b10)) ? pend_q[p] : dir_in[p];
      app_d[p]   = app_q[p];
      cur_x_d[p] = cur_x_q[p];
      cur_y_d[p] = cur_y_q[p];
      nx_d[p]    = nx_q[p];
      ny_d[p]    = ny_q[p];
    end
    case (state_q)
      IDLE: begin
        state_d = start ? RUN : IDLE;
        cnt_d   = '0;
      end
      RUN: begin
        state_d = (cnt_q == CW'(MOVE_PERIOD - 1)) ? STEP : RUN;
        cnt_d   = (cnt_q == CW'(MOVE_PERIOD - 1)) ? '0 : cnt_q + 1'b1;
      end
      STEP: begin
        state_d = CHECK;
        for (int p = 0; p < 2; p++) begin
          app_d[p] = pend_q[p];
          nx_d[p]  = (pend_q[p] == RIGHT) ? cur_x_q[p] + 8'd1 :
                     (pend_q[p] == LEFT)  ? cur_x_q[p] - 8'd1 : cur_x_q[p];
          ny_d[p]  = (pend_q[p] == DOWN)  ? cur_y_q[p] + 8'd1 :
                     (pend_q[p] == UP)    ? cur_y_q[p] - 8'd1 : cur_y_q[p];
        end
      end
      CHECK: begin
        state_d = (|crash) ? OVER : WRITE_P1;
        go_d    = |crash;
        win_d   = {crash[0], crash[1]};
        for (int p = 0; p < 2; p++) begin
          cur_x_d[p] = (|crash) ? cur_x_q[p] : nx_q[p];
          cur_y_d[p] = (|crash) ? cur_y_q[p] : ny_q[p];
        end
      end
      WRITE_P1: state_d = WRITE_P2;
      WRITE_P2: state_d = RUN;
      OVER:     state_d = OVER;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '{RIGHT, LEFT};
      app_q   <= '{RIGHT, LEFT};
      cur_x_q <= '{start_x_1, start_x_2};
      cur_y_q <= '{start_y_1, start_y_2};
      nx_q    <= '{start_x_1, start_x_2};
      ny_q    <= '{start_y_1, start_y_2};
      go_q    <= 1'b0;
      win_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      app_q   <= app_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      nx_q    <= nx_d;
      ny_q    <= ny_d;
      go_q    <= go_d;
      win_q   <= win_d;
    end
  end
  assign current_x_1     = cur_x_q[0];
  assign current_y_1     = cur_y_q[0];
  assign current_x_2     = cur_x_q[1];
  assign current_y_2     = cur_y_q[1];
  assign selected_player = (state_q == WRITE_P1) ? 2'b01 : (state_q == WRITE_P2) ? 2'b11 : 2'b00;
  assign game_over       = go_q;
  assign winner          = win_q;
endmodule

// File: tb/tb_player_control.sv
// tb_player_control: directed checks of movement, reversal filtering, crashes and reset priority.
module tb_player_control;
  import game_pkg::*;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [1:0] dir_1, dir_2;
  tile        map_r [MAP_WIDTH][MAP_HEIGHT];
  logic [7:0] current_x_1, current_y_1, current_x_2, current_y_2;
  logic [1:0] selected_player, winner;
  logic       game_over;
  int         errors = 0, checks = 0, n;
  logic       saw_sel;
  always #5 clk = ~clk;
  player_control #(.MOVE_PERIOD(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dir_1(dir_1), .dir_2(dir_2), .map(map_r),
    .current_x_1(current_x_1), .current_y_1(current_y_1),
    .current_x_2(current_x_2), .current_y_2(current_y_2),
    .selected_player(selected_player), .game_over(game_over), .winner(winner)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic build_map(input bit frame_x0);
    for (int x = 0; x < MAP_WIDTH; x++)
      for (int y = 0; y < MAP_HEIGHT; y++)
        map_r[x][y] = ((x == 0 && frame_x0) || x == MAP_WIDTH - 1 || y == 0 || y == MAP_HEIGHT - 1) ? FRAME : EMPTY;
  endtask
  task automatic do_reset();
    rst = 1'b1; start = 1'b0; dir_1 = 2'b01; dir_2 = 2'b11;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic start_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_sel(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (selected_player != 2'b01 && cnt < 100);
    check("sel_seen", 32'(selected_player == 2'b01), 1);
  endtask
  task automatic wait_over(output logic seen);
    int k = 0;
    seen = 1'b0;
    while (!game_over && k < 300) begin
      @(negedge clk);
      seen |= (selected_player != 2'b00);
      k++;
    end
    check("over_seen", 32'(game_over), 1);
  endtask
  initial begin
    build_map(1'b1);
    do_reset();
    check("rst_x1", current_x_1, 4);
    check("rst_y1", current_y_1, 6);
    check("rst_x2", current_x_2, 12);
    check("rst_y2", current_y_2, 6);
    check("rst_sel", selected_player, 0);
    check("rst_go", game_over, 0);
    check("rst_win", winner, 0);
    repeat (10) @(negedge clk);
    check("idle_sel", selected_player, 0);
    check("idle_x1", current_x_1, 4);
    // basic step and latency
    start_game();
    wait_sel(n);
    check("latency", n, 6);
    check("s1_x1", current_x_1, 5);
    check("s1_y1", current_y_1, 6);
    check("s1_x2", current_x_2, 11);
    check("s1_y2", current_y_2, 6);
    @(negedge clk);
    check("sel_p2", selected_player, 3);
    check("p2_x1_stable", current_x_1, 5);
    @(negedge clk);
    check("sel_none", selected_player, 0);
    // reversal ignored, then UP accepted
    do_reset();
    dir_1 = 2'b11;
    start_game();
    wait_sel(n);
    check("rev_x1", current_x_1, 5);
    check("rev_y1", current_y_1, 6);
    dir_1 = 2'b00;
    wait_sel(n);
    check("up_x1", current_x_1, 5);
    check("up_y1", current_y_1, 5);
    check("up_x2", current_x_2, 10);
    // obstacle in front of player2
    do_reset();
    map_r[11][6] = TRAIL_1;
    start_game();
    wait_over(saw_sel);
    check("obs_nosel", saw_sel, 0);
    check("obs_win", winner, 1);
    check("obs_x1", current_x_1, 4);
    check("obs_x2", current_x_2, 12);
    start_game();
    repeat (20) @(negedge clk);
    check("over_go", game_over, 1);
    check("over_win", winner, 1);
    check("over_x2", current_x_2, 12);
    check("over_sel", selected_player, 0);
    build_map(1'b1);
    // head-on into the same tile
    do_reset();
    start_game();
    wait_over(saw_sel);
    check("draw_win", winner, 3);
    check("draw_x1", current_x_1, 7);
    check("draw_x2", current_x_2, 9);
    // player1 into the left frame
    do_reset();
    dir_1 = 2'b00;
    start_game();
    wait_sel(n);
    check("fr_y1", current_y_1, 5);
    dir_1 = 2'b11;
    wait_over(saw_sel);
    check("fr_win", winner, 2);
    check("fr_x1", current_x_1, 1);
    check("fr_y1b", current_y_1, 5);
    check("fr_x2", current_x_2, 8);
    // no frame at x=0: wrap to 255 is out of range
    build_map(1'b0);
    do_reset();
    dir_1 = 2'b00;
    start_game();
    wait_sel(n);
    dir_1 = 2'b11;
    wait_over(saw_sel);
    check("wrap_win", winner, 2);
    check("wrap_x1", current_x_1, 0);
    check("wrap_x2", current_x_2, 7);
    build_map(1'b1);
    // reset during WRITE_P1
    do_reset();
    start_game();
    wait_sel(n);
    rst = 1'b1;
    @(negedge clk);
    check("rw_sel", selected_player, 0);
    check("rw_x1", current_x_1, 4);
    check("rw_x2", current_x_2, 12);
    check("rw_go", game_over, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("rw_idle_sel", selected_player, 0);
    check("rw_idle_x1", current_x_1, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
